unpacker_param: RTL

Parametrised successor to the fixed 160B→32B unpacker FSM. It splits one wide input beat carrying up to IN_BYTES valid bytes into ceil(vbc/OUT_BYTES) narrow output beats, preserving packet framing (sop/eop). It adds downstream backpressure (out_ready), zero-bubble back-to-back beats, and error detection. It sits between the wide packet datapath and narrower egress logic.

---
 rtl/unpacker_pkg.sv | 19 +
 rtl/unpacker_chunk_sel.sv | 48 ++++
 rtl/unpacker_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/unpacker_pkg.sv
// rtl/unpacker_pkg.sv - shared types and helpers for the wide-to-narrow beat unpacker
package unpacker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpack_state_e;

    localparam int unsigned DEF_IN_BYTES  = 160;
    localparam int unsigned DEF_OUT_BYTES = 32;

    // Number of narrow beats needed to carry vbc bytes.
    function automatic int unsigned num_chunks(input int unsigned vbc, input int unsigned out_bytes);
        return (vbc + out_bytes - 1) / out_bytes;
    endfunction

    localparam int unsigned MAX_CHUNKS = (DEF_IN_BYTES + DEF_OUT_BYTES - 1) / DEF_OUT_BYTES;

endpackage

// File: rtl/unpacker_chunk_sel.sv
// rtl/unpacker_chunk_sel.sv - combinational pick of one narrow chunk from the buffered wide beat
module unpacker_chunk_sel
    import unpacker_pkg::*;
#(
    parameter int IN_BYTES  = 160,
    parameter int OUT_BYTES = 32,
    parameter int VBC_W     = $clog2(IN_BYTES + 1),
    parameter int OVBC_W    = $clog2(OUT_BYTES + 1),
    parameter int IDX_W     = $clog2(num_chunks(IN_BYTES, OUT_BYTES) + 1)
) (
    input  logic [IN_BYTES*8-1:0]  buf_data,
    input  logic [VBC_W-1:0]       buf_vbc,
    input  logic [IDX_W-1:0]       idx,
    output logic [OUT_BYTES*8-1:0] chunk_data,
    output logic [OVBC_W-1:0]      chunk_vbc
);

    localparam int OUT_W = OUT_BYTES * 8;

    logic [31:0]      base;
    logic [31:0]      remain;
    logic [OUT_W-1:0] window;

    // Byte offset of the chunk is done in 32 bits so idx*OUT_BYTES never truncates;
    // the right shift pulls in zeros for anything past IN_BYTES.
    assign base   = 32'(idx) * 32'(OUT_BYTES);
    assign remain = 32'(buf_vbc) - base;
    assign window = OUT_W'(buf_data >> (base * 32'd8));

    // Zero every byte of the window that lies at or beyond the beat's valid count.
    always_comb begin
        chunk_data = '0;
        for (int j = 0; j < OUT_BYTES; j++) begin
            if (base + 32'(j) < 32'(buf_vbc)) begin
                chunk_data[j*8 +: 8] = window[j*8 +: 8];
            end
        end
    end

    // Full chunks carry OUT_BYTES; the tail chunk carries whatever is left.
    always_comb begin
        chunk_vbc = OVBC_W'(remain);
        if (remain >= 32'(OUT_BYTES)) begin
            chunk_vbc = OVBC_W'(OUT_BYTES);
        end
    end

endmodule

// File: rtl/unpacker_param.sv
// rtl/unpacker_param.sv - splits one wide packet beat into narrow beats with backpressure and error flagging
module unpacker_param
    import unpacker_pkg::*;
#(
    parameter int IN_BYTES  = 160,
    parameter int OUT_BYTES = 32,
    parameter int VBC_W     = $clog2(IN_BYTES + 1),
    parameter int OVBC_W    = $clog2(OUT_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [VBC_W-1:0]       in_vbc,
    input  logic [IN_BYTES*8-1:0]  in_data,
    output logic                   in_ready,
    output logic                   out_val,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [OVBC_W-1:0]      out_vbc,
    output logic [OUT_BYTES*8-1:0] out_data,
    input  logic                   out_ready,
    output logic                   idle,
    output logic                   err
);

    localparam int unsigned MAX_CHK = num_chunks(IN_BYTES, OUT_BYTES);
    localparam int          IDX_W   = $clog2(MAX_CHK + 1);

    unpack_state_e          state_q, state_d;
    logic [IN_BYTES*8-1:0]  buf_data_q;
    logic                   buf_sop_q;
    logic                   buf_eop_q;
    logic [VBC_W-1:0]       buf_vbc_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       nchk_q;
    logic                   pkt_open_q;
    logic                   err_q;

    logic                   send_st;
    logic                   last_chunk;
    logic                   out_fire;
    logic                   accept;
    logic                   bad_vbc;
    logic                   load;
    logic [OUT_BYTES*8-1:0] sel_data;
    logic [OVBC_W-1:0]      sel_vbc;

    assign send_st    = (state_q == SEND);
    assign last_chunk = (idx_q == nchk_q - IDX_W'(1));
    assign out_fire   = send_st && out_ready;

    // A new beat may enter when the buffer is empty or its final chunk leaves this cycle.
    assign in_ready = !reset && (!send_st || (last_chunk && out_ready));
    assign accept   = in_val && in_ready;
    assign bad_vbc  = (in_vbc == '0) || (32'(in_vbc) > 32'(IN_BYTES));
    assign load     = accept && !bad_vbc;

    unpacker_chunk_sel #(
        .IN_BYTES  (IN_BYTES),
        .OUT_BYTES (OUT_BYTES),
        .VBC_W     (VBC_W),
        .OVBC_W    (OVBC_W),
        .IDX_W     (IDX_W)
    ) u_chunk_sel (
        .buf_data   (buf_data_q),
        .buf_vbc    (buf_vbc_q),
        .idx        (idx_q),
        .chunk_data (sel_data),
        .chunk_vbc  (sel_vbc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and output beat; outputs read as zero whenever the buffer is empty.
    always_comb begin
        state_d  = state_q;
        out_val  = 1'b0;
        out_sop  = 1'b0;
        out_eop  = 1'b0;
        out_vbc  = '0;
        out_data = '0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                out_val  = 1'b1;
                out_sop  = buf_sop_q && (idx_q == '0);
                out_eop  = buf_eop_q && last_chunk;
                out_vbc  = sel_vbc;
                out_data = sel_data;
                if (out_fire && last_chunk) begin
                    state_d = load ? SEND : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat buffer, chunk counter, packet framing tracker and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_data_q <= '0;
            buf_sop_q  <= 1'b0;
            buf_eop_q  <= 1'b0;
            buf_vbc_q  <= '0;
            idx_q      <= '0;
            nchk_q     <= '0;
            pkt_open_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Bad count, sop inside an open packet, or a non-sop beat outside one.
            err_q <= accept && (bad_vbc || (in_sop == pkt_open_q));
            if (load) begin
                buf_data_q <= in_data;
                buf_sop_q  <= in_sop;
                buf_eop_q  <= in_eop;
                buf_vbc_q  <= in_vbc;
                idx_q      <= '0;
                nchk_q     <= IDX_W'(num_chunks(32'(in_vbc), OUT_BYTES));
                if (in_eop) begin
                    pkt_open_q <= 1'b0;
                end else if (in_sop) begin
                    pkt_open_q <= 1'b1;
                end
            end else if (out_fire && !last_chunk) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign idle = !send_st;
    assign err  = err_q;

endmodule
